// File: rtl/alu_operand_join_pkg.sv
// Purpose : shared types and constants for the ALU operand join stage.
// Contents: config bit positions, config type, and a helper that tells whether
//           a configuration requests any operand at all.
package alu_operand_join_pkg;

  // Bit positions inside config_sig shared by the function cells
  localparam int unsigned REQ_IN0 = 0;
  localparam int unsigned REQ_IN1 = 1;

  typedef logic [1:0] cfg_t;

  // A configuration with no required operand never issues a pair
  function automatic logic cfg_active(input cfg_t cfg);
    return (cfg != 2'b00);
  endfunction

endpackage

// File: rtl/alu_operand_join_if.sv
// Purpose : bundles the operand-join handshake and configuration signals.
// Ports   : config_sig/flush (control), in0/in1 with valid/ready (operand
//           streams from the fabric), out0/out1 with valid/ready (joined pair
//           to the ALU). master = fabric/ALU side, slave = the join stage.
interface alu_operand_join_if #(
  parameter int size = 32
) ();
  import alu_operand_join_pkg::*;

  cfg_t            config_sig;
  logic            flush;
  logic [size-1:0] in0;
  logic            in0_valid;
  logic            in0_ready;
  logic [size-1:0] in1;
  logic            in1_valid;
  logic            in1_ready;
  logic [size-1:0] out0;
  logic [size-1:0] out1;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output config_sig, flush, in0, in0_valid, in1, in1_valid, out_ready,
    input  in0_ready, in1_ready, out0, out1, out_valid
  );

  modport slave (
    input  config_sig, flush, in0, in0_valid, in1, in1_valid, out_ready,
    output in0_ready, in1_ready, out0, out1, out_valid
  );
endinterface

// File: rtl/alu_operand_fifo.sv
// Purpose : synchronous operand FIFO with push/pop/flush.
// Ports   : clk, rst_n (async active-low), flush (sync clear, highest
//           priority), push/push_data, pop/pop_data (head, valid when !empty),
//           full, empty. A full FIFO refuses a push even when it pops in the
//           same cycle; a pop on an empty FIFO is ignored.
module alu_operand_fifo #(
  parameter int size  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [size-1:0] push_data,
  input  logic            pop,
  output logic [size-1:0] pop_data,
  output logic            full,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [size-1:0] mem_q [DEPTH];
  logic [size-1:0] mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_en_s;
  logic            pop_en_s;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == {CW{1'b0}});
  assign pop_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; flush overrides everything
  always_comb begin
    push_en_s = push & ~full;
    pop_en_s  = pop & ~empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_en_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {size{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/alu_operand_join.sv
// Purpose : operand stage in front of the ALU function cell. Buffers the in0
//           and in1 streams in per-port FIFOs and issues a registered operand
//           pair once every operand required by config_sig is queued.
// Ports   : clk, rst_n (async active-low), bus (slave modport of
//           alu_operand_join_if: config_sig, flush, in0/in1 valid/ready,
//           out0/out1/out_valid/out_ready).
module alu_operand_join
  import alu_operand_join_pkg::*;
#(
  parameter int size  = 32,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_operand_join_if.slave bus
);
  logic            full0_s, full1_s, empty0_s, empty1_s;
  logic [size-1:0] head0_s, head1_s;
  logic            push0_s, push1_s, pop0_s, pop1_s;
  logic            fire_s;
  logic            in0_ready_s, in1_ready_s;

  // live_q holds ready low during reset and for no longer than the first edge
  logic            live_q, live_d;
  logic [size-1:0] out0_q, out0_d;
  logic [size-1:0] out1_q, out1_d;
  logic            out_valid_q, out_valid_d;

  // Ready depends only on registered state: no path from valid or out_ready
  assign in0_ready_s = live_q & ~full0_s;
  assign in1_ready_s = live_q & ~full1_s;
  assign push0_s     = bus.in0_valid & in0_ready_s;
  assign push1_s     = bus.in1_valid & in1_ready_s;

  assign fire_s = cfg_active(bus.config_sig)
                & (~bus.config_sig[REQ_IN0] | ~empty0_s)
                & (~bus.config_sig[REQ_IN1] | ~empty1_s)
                & (~out_valid_q | bus.out_ready);

  // A non-required FIFO is never popped, so unpaired entries stay queued
  assign pop0_s = fire_s & bus.config_sig[REQ_IN0];
  assign pop1_s = fire_s & bus.config_sig[REQ_IN1];

  alu_operand_fifo #(.size(size), .DEPTH(DEPTH)) u_fifo0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.flush),
    .push     (push0_s),
    .push_data(bus.in0),
    .pop      (pop0_s),
    .pop_data (head0_s),
    .full     (full0_s),
    .empty    (empty0_s)
  );

  alu_operand_fifo #(.size(size), .DEPTH(DEPTH)) u_fifo1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.flush),
    .push     (push1_s),
    .push_data(bus.in1),
    .pop      (pop1_s),
    .pop_data (head1_s),
    .full     (full1_s),
    .empty    (empty1_s)
  );

  // Output register next-state: flush, then fire, then consume, else hold
  always_comb begin
    live_d      = 1'b1;
    out0_d      = out0_q;
    out1_d      = out1_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      out0_d      = {size{1'b0}};
      out1_d      = {size{1'b0}};
      out_valid_d = 1'b0;
    end else if (fire_s) begin
      out0_d      = bus.config_sig[REQ_IN0] ? head0_s : {size{1'b0}};
      out1_d      = bus.config_sig[REQ_IN1] ? head1_s : {size{1'b0}};
      out_valid_d = 1'b1;
    end else if (out_valid_q & bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output and ready-enable registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q      <= 1'b0;
      out0_q      <= {size{1'b0}};
      out1_q      <= {size{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      live_q      <= live_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in0_ready = in0_ready_s;
  assign bus.in1_ready = in1_ready_s;
  assign bus.out0      = out0_q;
  assign bus.out1      = out1_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_operand_join.sv
// Directed testbench for alu_operand_join (size=32, DEPTH=4). Inputs change
// 1 time unit after a rising edge; outputs are checked at that same point.
module tb_alu_operand_join;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_operand_join_if #(.size(32)) bus ();

  alu_operand_join #(.size(32), .DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0       = 32'd0;
    bus.in1       = 32'd0;
    bus.flush     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    idle_inputs();
    bus.config_sig = 2'b00;
    bus.out_ready  = 1'b0;
    #3;
    n_checks++;
    if ({bus.out_valid, bus.out0, bus.out1, bus.in0_ready, bus.in1_ready} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b out0=%0d out1=%0d rdy=%b%b want all 0",
               bus.out_valid, bus.out0, bus.out1, bus.in0_ready, bus.in1_ready);
    end
    #9 rst_n = 1'b1;
    step();
    n_checks++;
    if ({bus.in0_ready, bus.in1_ready, bus.out_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_release: rdy/valid=%b want 110",
               {bus.in0_ready, bus.in1_ready, bus.out_valid});
    end
  endtask

  task automatic test_latency();
    bus.config_sig = 2'b11;
    bus.out_ready  = 1'b1;
    bus.in0 = 32'd5; bus.in0_valid = 1'b1;
    step();
    bus.in0_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_wait_in1: out_valid=%b want 0", bus.out_valid);
    end
    bus.in1 = 32'd7; bus.in1_valid = 1'b1;
    step();
    bus.in1_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_no_bypass: out_valid=%b want 0", bus.out_valid);
    end
    step();
    n_checks++;
    if ({bus.out_valid, bus.out0, bus.out1} !== {1'b1, 32'd5, 32'd7}) begin
      n_fail++;
      $display("FAIL lat_pair: valid=%b out0=%0d out1=%0d want 1 5 7",
               bus.out_valid, bus.out0, bus.out1);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_consume: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_in0_only();
    bus.config_sig = 2'b01;
    bus.out_ready  = 1'b1;
    bus.in0 = 32'd3; bus.in0_valid = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        bus.in0 = 32'd4 + 32'(k);
      end else begin
        bus.in0_valid = 1'b0;
      end
      step();
      n_checks++;
      if ({bus.out_valid, bus.out0, bus.out1} !== {1'b1, 32'd3 + 32'(k), 32'd0}) begin
        n_fail++;
        $display("FAIL in0_only_pair%0d: valid=%b out0=%0d out1=%0d want 1 %0d 0",
                 k, bus.out_valid, bus.out0, bus.out1, 3 + k);
      end
    end
    step();
    n_checks++;
    if ({bus.out_valid, bus.in1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL in0_only_end: valid/in1_ready=%b want 01", {bus.out_valid, bus.in1_ready});
    end
  endtask

  task automatic test_backpressure();
    bus.config_sig = 2'b11;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in0 = 32'd10 + 32'(i); bus.in1 = 32'd20 + 32'(i);
      bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
      step();
    end
    n_checks++;
    if ({bus.in0_ready, bus.in1_ready, bus.out_valid, bus.out0, bus.out1} !==
        {2'b00, 1'b1, 32'd10, 32'd20}) begin
      n_fail++;
      $display("FAIL bp_full: rdy=%b%b valid=%b out0=%0d out1=%0d want 00 1 10 20",
               bus.in0_ready, bus.in1_ready, bus.out_valid, bus.out0, bus.out1);
    end
    bus.in0 = 32'd99; bus.in1 = 32'd99;
    step();
    n_checks++;
    if ({bus.in0_ready, bus.in1_ready, bus.out_valid, bus.out0, bus.out1} !==
        {2'b00, 1'b1, 32'd10, 32'd20}) begin
      n_fail++;
      $display("FAIL bp_hold: rdy=%b%b valid=%b out0=%0d out1=%0d want 00 1 10 20",
               bus.in0_ready, bus.in1_ready, bus.out_valid, bus.out0, bus.out1);
    end
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      step();
      n_checks++;
      if ({bus.in0_ready, bus.in1_ready, bus.out_valid, bus.out0, bus.out1} !==
          {2'b11, 1'b1, 32'd10 + 32'(j), 32'd20 + 32'(j)}) begin
        n_fail++;
        $display("FAIL bp_drain%0d: rdy=%b%b valid=%b out0=%0d out1=%0d want 11 1 %0d %0d",
                 j, bus.in0_ready, bus.in1_ready, bus.out_valid, bus.out0, bus.out1,
                 10 + j, 20 + j);
      end
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.config_sig = 2'b11;
    bus.out_ready  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      bus.in0 = 32'd100 + 32'(k - 1); bus.in1 = 32'd200 + 32'(k - 1);
      bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
      step();
      if (k >= 2) begin
        n_checks++;
        if ({bus.in0_ready, bus.in1_ready, bus.out_valid, bus.out0, bus.out1} !==
            {2'b11, 1'b1, 32'd100 + 32'(k - 2), 32'd200 + 32'(k - 2)}) begin
          n_fail++;
          $display("FAIL b2b_cyc%0d: rdy=%b%b valid=%b out0=%0d out1=%0d want 11 1 %0d %0d",
                   k, bus.in0_ready, bus.in1_ready, bus.out_valid, bus.out0, bus.out1,
                   100 + k - 2, 200 + k - 2);
        end
      end
    end
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    step();
    n_checks++;
    if ({bus.out_valid, bus.out0, bus.out1} !== {1'b1, 32'd119, 32'd219}) begin
      n_fail++;
      $display("FAIL b2b_last: valid=%b out0=%0d out1=%0d want 1 119 219",
               bus.out_valid, bus.out0, bus.out1);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drained: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.config_sig = 2'b11;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in0 = 32'd30 + 32'(i); bus.in1 = 32'd40 + 32'(i);
      bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
      step();
    end
    bus.in1_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.out0, bus.out1} !== {1'b1, 32'd30, 32'd40}) begin
      n_fail++;
      $display("FAIL flush_pre: valid=%b out0=%0d out1=%0d want 1 30 40",
               bus.out_valid, bus.out0, bus.out1);
    end
    bus.flush = 1'b1; bus.in0 = 32'd77; bus.in0_valid = 1'b1;
    step();
    bus.flush = 1'b0; bus.in0_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.out0, bus.out1, bus.in0_ready, bus.in1_ready} !==
        {1'b0, 32'd0, 32'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL flush_state: valid=%b out0=%0d out1=%0d rdy=%b%b want 0 0 0 11",
               bus.out_valid, bus.out0, bus.out1, bus.in0_ready, bus.in1_ready);
    end
    bus.out_ready  = 1'b1;
    bus.config_sig = 2'b01;
    step();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_fifo0_empty: out_valid=%b out0=%0d want 0", bus.out_valid, bus.out0);
    end
    bus.config_sig = 2'b10;
    step();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_fifo1_empty: out_valid=%b out1=%0d want 0", bus.out_valid, bus.out1);
    end
  endtask

  task automatic test_async_reset();
    bus.config_sig = 2'b11;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in0 = 32'd50 + 32'(i); bus.in1 = 32'd60 + 32'(i);
      bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
      step();
    end
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.out0, bus.out1} !== {1'b1, 32'd50, 32'd60}) begin
      n_fail++;
      $display("FAIL arst_pre: valid=%b out0=%0d out1=%0d want 1 50 60",
               bus.out_valid, bus.out0, bus.out1);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out0, bus.out1, bus.in0_ready, bus.in1_ready} !== 67'd0) begin
      n_fail++;
      $display("FAIL arst_immediate: valid=%b out0=%0d out1=%0d rdy=%b%b want all 0",
               bus.out_valid, bus.out0, bus.out1, bus.in0_ready, bus.in1_ready);
    end
    #10 rst_n = 1'b1;
    step();
    n_checks++;
    if ({bus.in0_ready, bus.in1_ready, bus.out_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL arst_release: rdy/valid=%b want 110",
               {bus.in0_ready, bus.in1_ready, bus.out_valid});
    end
    bus.out_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_empty: out_valid=%b want 0", bus.out_valid);
    end
    bus.in0 = 32'd3; bus.in1 = 32'd4;
    bus.in0_valid = 1'b1; bus.in1_valid = 1'b1;
    step();
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    step();
    n_checks++;
    if ({bus.out_valid, bus.out0, bus.out1} !== {1'b1, 32'd3, 32'd4}) begin
      n_fail++;
      $display("FAIL arst_after_pair: valid=%b out0=%0d out1=%0d want 1 3 4",
               bus.out_valid, bus.out0, bus.out1);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_in0_only();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
